// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive deframer driven by an external baud generator.
// Samples rx on the generator's mid-bit strobe, realigns the generator on every
// start edge, and presents each good byte under a valid/ack handshake with
// frame-error, parity-error and sticky overrun flags.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit before the stop bit).
module uart_rx_frame #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 sample_tick,
    output logic                 baud_en,
    output logic                 baud_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_p;
    logic                   fall;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;

`ifdef UART_RX_PARITY_EN
    logic                   par_bit;

    // Even parity: the received bit must equal the XOR of the data bits.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
        return p != (^d);
    endfunction
`endif

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = rx_p & ~rx_s;
    assign busy = (state != IDLE);

    // Metastability synchronizer plus one-cycle history for edge detection; idle level is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            rx_p   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_p   <= rx_s;
        end
    end

    // Shift register only fills during DATA; its contents are don't-care outside a frame.
    always_ff @(posedge clk) begin
        if (state == DATA && sample_tick)
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
        if (state == PARITY && sample_tick)
            par_bit <= rx_s;
`endif
    end

    // Frame state machine with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            baud_en    <= 1'b0;
            baud_clr   <= 1'b0;
            bit_cnt    <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            baud_clr   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // Ack clears first; a completion in the same cycle overrides it below.
            if (rx_ack && rx_valid)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (fall) begin
                        baud_clr <= 1'b1;
                        baud_en  <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (sample_tick) begin
                        if (rx_s) begin
                            baud_en <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample_tick)
                        state <= STOP;
                end
`endif
                STOP: begin
                    if (sample_tick) begin
                        baud_en <= 1'b0;
                        state   <= IDLE;
                        if (rx_s) begin
                            rx_data  <= shift_q;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rx_ack)
                                overrun <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        parity_err <= parity_mismatch(shift_q, par_bit);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a behavioural 16x baud generator.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       sample_tick;
    logic       baud_en;
    logic       baud_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    uart_rx_frame #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .sample_tick(sample_tick),
        .baud_en    (baud_en),
        .baud_clr   (baud_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Baud generator model, SIZE=16: strobe 7 cycles after the clear, then every 16.
    logic [3:0] bcnt = 4'd0;
    always @(posedge clk) begin
        if (rst || baud_clr) bcnt <= 4'd0;
        else if (baud_en)    bcnt <= bcnt + 4'd1;
    end
    assign sample_tick = baud_en && !baud_clr && (bcnt == 4'd7);

    // Event monitor sampled on the falling edge.
    int   cyc = 0, last_tick = 0, lat = 0, rises = 0, fe_cnt = 0, pe_cnt = 0, clr_cnt = 0;
    logic pv = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sample_tick) last_tick <= cyc;
        if (rx_valid && !pv) begin
            lat   <= cyc - last_tick;
            rises <= rises + 1;
        end
        pv <= rx_valid;
        if (frame_err)  fe_cnt  <= fe_cnt + 1;
        if (parity_err) pe_cnt  <= pe_cnt + 1;
        if (baud_clr)   clr_cnt <= clr_cnt + 1;
    end

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame, 16 clocks per bit; leaves rx at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        rx = 1'b0;
        clocks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            clocks(16);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        clocks(16);
`else
        if (par) rx = 1'b1;
`endif
        rx = stop;
        clocks(16);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        clocks(1);
        rx_ack = 1'b0;
    endtask

    initial begin
        int base_rises, base_clr;
        clocks(4);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_baud_en", baud_en, 0);
        chk("rst_baud_clr", baud_clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        clocks(8);

        // Good frame 0xA5.
        send_frame(8'hA5, 1'b0, 1'b1);
        clocks(4);
        chk("a5_data", rx_data, 32'hA5);
        chk("a5_valid", rx_valid, 1);
        chk("a5_latency", lat, 1);
        chk("a5_frame_err", fe_cnt, 0);
        chk("a5_baud_en", baud_en, 0);
        chk("a5_clr_pulses", clr_cnt, 1);
        ack_pulse();
        chk("a5_ack_clears", rx_valid, 0);
        clocks(4);

        // False start: 4 clocks low then back high.
        base_rises = rises;
        rx = 1'b0;
        clocks(4);
        rx = 1'b1;
        clocks(2);
        chk("fs_busy_during", busy, 1);
        chk("fs_baud_en_during", baud_en, 1);
        clocks(30);
        chk("fs_busy_after", busy, 0);
        chk("fs_baud_en_after", baud_en, 0);
        chk("fs_no_valid", rises, base_rises);

        // Frame error 0x3C with stop low, line held low afterwards.
        send_frame(8'h3C, 1'b0, 1'b0);
        clocks(1);
        chk("fe_pulse_count", fe_cnt, 1);
        chk("fe_valid", rx_valid, 0);
        chk("fe_data_kept", rx_data, 32'hA5);
        base_clr = clr_cnt;
        clocks(40);
        chk("fe_no_retrigger_busy", busy, 0);
        chk("fe_no_retrigger_clr", clr_cnt, base_clr);
        rx = 1'b1;
        clocks(20);

        // Overrun: 0x11 then 0x22 without ack.
        send_frame(8'h11, 1'b0, 1'b1);
        clocks(4);
        chk("ov_first_data", rx_data, 32'h11);
        chk("ov_first_flag", overrun, 0);
        send_frame(8'h22, 1'b0, 1'b1);
        clocks(4);
        chk("ov_second_data", rx_data, 32'h22);
        chk("ov_set", overrun, 1);
        chk("ov_valid", rx_valid, 1);
        ack_pulse();
        chk("ov_ack_clears", rx_valid, 0);
        clocks(10);
        chk("ov_sticky", overrun, 1);

        // Reset in the middle of 0xFF data bits.
        rx = 1'b0;
        clocks(16);
        rx = 1'b1;
        clocks(64);
        chk("mr_busy_before", busy, 1);
        rst = 1'b1;
        clocks(1);
        rst = 1'b0;
        chk("mr_busy", busy, 0);
        chk("mr_baud_en", baud_en, 0);
        chk("mr_overrun", overrun, 0);
        chk("mr_rx_data", rx_data, 0);
        chk("mr_rx_valid", rx_valid, 0);
        clocks(100);
        send_frame(8'h5A, 1'b0, 1'b1);
        clocks(4);
        chk("mr_next_data", rx_data, 32'h5A);
        chk("mr_next_valid", rx_valid, 1);
        chk("mr_next_overrun", overrun, 0);
        ack_pulse();
        clocks(4);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1);
        clocks(4);
        chk("par_bad_pulse", pe_cnt, 1);
        chk("par_bad_data", rx_data, 32'h07);
        ack_pulse();
        clocks(4);
        send_frame(8'h07, 1'b1, 1'b1);
        clocks(4);
        chk("par_good_no_pulse", pe_cnt, 1);
        chk("par_good_data", rx_data, 32'h07);
`else
        chk("par_disabled", pe_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
